// File: rtl/vram_line_fetch_if.sv
// rtl/vram_line_fetch_if.sv - VRAM port B and pixel word stream bundle
//
// Purpose: groups the read port of the dual-port video RAM with the word
// stream that feeds the pixel serializer.
//
// Signals:
//   vram_addr  : word address to VRAM port B (fetch engine -> RAM)
//   vram_we    : port B write enable, always low from the fetch engine
//   vram_wdata : port B write data, always zero from the fetch engine
//   vram_q     : port B read data, one cycle after vram_addr (RAM -> engine)
//   px_data    : stream word, FIFO head (engine -> serializer)
//   px_valid   : stream word valid (engine -> serializer)
//   px_ready   : serializer accepts the word (serializer -> engine)
//
// Modports: master = fetch engine, slave = RAM plus serializer side.
interface vram_line_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_we;
  logic [DATA_W-1:0] vram_wdata;
  logic [DATA_W-1:0] vram_q;
  logic [DATA_W-1:0] px_data;
  logic              px_valid;
  logic              px_ready;

  modport master (
    output vram_addr, vram_we, vram_wdata, px_data, px_valid,
    input  vram_q, px_ready
  );

  modport slave (
    input  vram_addr, vram_we, vram_wdata, px_data, px_valid,
    output vram_q, px_ready
  );
endinterface

// File: rtl/vram_line_fetch.sv
// rtl/vram_line_fetch.sv - scanline read engine for VRAM port B with output FIFO
//
// Purpose: on a start pulse, reads LINE_WORDS consecutive words from VRAM
// port B beginning at base_addr, absorbs the one-cycle RAM read latency and
// buffers the words in a FIFO_DEPTH-entry FIFO that drives a valid/ready
// word stream to the pixel serializer.
//
// Ports:
//   clock     : single clock, rising edge
//   reset_n   : synchronous active-low reset
//   start     : one-cycle pulse, begins (or restarts) a line fetch
//   base_addr : first word address, sampled with start
//   bus       : vram_line_fetch_if master (VRAM port B + pixel stream)
//   busy      : line in progress, drops in the cycle of the last handshake
//   done      : one-cycle pulse on the pop of the last word of a line
//   underrun  : sticky, consumer was ready on an empty FIFO mid-line
//
// Optional feature: define VRAM_FETCH_WRAP_EN to keep the address walk inside
// the WRAP_MASK window selected by base_addr; otherwise the address simply
// increments modulo 2**ADDR_W.
module vram_line_fetch #(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 32,
  parameter int                LINE_WORDS = 160,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] WRAP_MASK  = 16'h3FFF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  vram_line_fetch_if.master        bus,
  output logic                     busy,
  output logic                     done,
  output logic                     underrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ISS_W = $clog2(LINE_WORDS + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_next;
  logic [ISS_W-1:0]  issued;
  logic              in_flight;
  logic              popped_any;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fill;
  logic              issue;
  logic              push;
  logic              pop;
  logic              last_pop;

`ifdef VRAM_FETCH_WRAP_EN
  // Bits outside the window stay fixed, so the walk wraps inside the
  // window that base_addr selects.
  assign addr_next = (addr & ~WRAP_MASK) | ((addr + ADDR_W'(1)) & WRAP_MASK);
`else
  assign addr_next = addr + ADDR_W'(1);
  // WRAP_MASK has no role in linear mode.
  logic unused_wrap_mask;
  assign unused_wrap_mask = ^WRAP_MASK;
`endif

  // Port B is read-only from this block.
  assign bus.vram_addr  = addr;
  assign bus.vram_we    = 1'b0;
  assign bus.vram_wdata = '0;

  assign bus.px_valid = (fill != '0);
  assign bus.px_data  = bus.px_valid ? mem[rd_ptr] : '0;

  // A read only issues when the FIFO can take it next cycle even with
  // no pop, so the push that follows never lands in a full FIFO.
  assign issue = (state == FETCH) && (int'(issued) < LINE_WORDS) &&
                 (int'(fill) + int'(in_flight) < FIFO_DEPTH);

  // A start discards the word returning this cycle.
  assign push = in_flight && reset_n && !start;
  assign pop  = bus.px_valid && bus.px_ready;

  // done/busy must move in the same cycle as the final handshake, so they
  // are decoded from the handshake rather than registered.
  assign last_pop = (state == DRAIN) && pop && (fill == CNT_W'(1)) && !in_flight;
  assign done     = last_pop;
  assign busy     = (state != IDLE) && !last_pop;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= bus.vram_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr       <= '0;
      issued     <= '0;
      in_flight  <= 1'b0;
      popped_any <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      underrun   <= 1'b0;
    end else if (start) begin
      // Same handling from IDLE or mid-line: an active line is abandoned.
      state      <= FETCH;
      addr       <= base_addr;
      issued     <= '0;
      in_flight  <= 1'b0;
      popped_any <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      underrun   <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        addr   <= addr_next;
        issued <= issued + ISS_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        popped_any <= 1'b1;
      end
      case ({push, pop})
        2'b10:   fill <= fill + CNT_W'(1);
        2'b01:   fill <= fill - CNT_W'(1);
        default: fill <= fill;
      endcase
      if ((state == FETCH) && bus.px_ready && !bus.px_valid && popped_any) begin
        underrun <= 1'b1;
      end
      case (state)
        FETCH: begin
          if (issue && (int'(issued) + 1 == LINE_WORDS)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_pop) begin
            state <= IDLE;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_line_fetch.sv
// tb/tb_vram_line_fetch.sv - randomized scoreboard bench for vram_line_fetch
module tb_vram_line_fetch;

  localparam int          AW          = 16;
  localparam int          DW          = 32;
  localparam int          DEPTH       = 8;
  localparam int          SHORT_WORDS = 4;
  localparam int          LONG_WORDS  = 12;
  localparam logic [15:0] MASK        = 16'h3FFF;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_s = 1'b0;
  logic [15:0] base_s  = '0;
  logic        busy_s, done_s, underrun_s;
  logic        start_l = 1'b0;
  logic [15:0] base_l  = '0;
  logic        busy_l, done_l, underrun_l;

  always #5 clock = ~clock;

  vram_line_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus_s ();
  vram_line_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus_l ();

  vram_line_fetch #(
    .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(SHORT_WORDS), .FIFO_DEPTH(DEPTH), .WRAP_MASK(MASK)
  ) u_short (
    .clock(clock), .reset_n(reset_n), .start(start_s), .base_addr(base_s),
    .bus(bus_s), .busy(busy_s), .done(done_s), .underrun(underrun_s)
  );

  vram_line_fetch #(
    .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LONG_WORDS), .FIFO_DEPTH(DEPTH), .WRAP_MASK(MASK)
  ) u_long (
    .clock(clock), .reset_n(reset_n), .start(start_l), .base_addr(base_l),
    .bus(bus_l), .busy(busy_l), .done(done_l), .underrun(underrun_l)
  );

  // VRAM content: low half equals the address, high half a scrambled copy.
  function automatic logic [31:0] word_of(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  // Address of the i-th word of a line starting at base.
  function automatic logic [15:0] addr_at(input logic [15:0] base, input int i);
    logic [15:0] lin;
    lin = base + 16'(i);
`ifdef VRAM_FETCH_WRAP_EN
    return (base & ~MASK) | (lin & MASK);
`else
    return lin;
`endif
  endfunction

  // Registered-read RAM behind each port B.
  always @(posedge clock) begin
    bus_s.vram_q <= word_of(bus_s.vram_addr);
    bus_l.vram_q <= word_of(bus_l.vram_addr);
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard for the long instance: expected words of the current line.
  logic [31:0] exp_q[$];
  bit          mon_en   = 0;
  bit          active   = 0;
  bit          exp_urun = 0;
  int          pops     = 0;
  int          dones    = 0;

  always @(negedge clock) begin
    bit hs;
    bit exp_done;
    if (mon_en) begin
      hs       = bus_l.px_valid && bus_l.px_ready;
      exp_done = 0;
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("stray_word", exp_q.size(), 1);
        end else begin
          chk("px_data", bus_l.px_data, exp_q.pop_front());
          pops++;
          exp_done = active && (exp_q.size() == 0);
        end
      end
      chk("done", done_l, exp_done);
      chk("busy", busy_l, active && !exp_done);
      chk("underrun", underrun_l, exp_urun);
      if (exp_done) begin
        active = 0;
        dones++;
      end
      if (active && bus_l.px_ready && !bus_l.px_valid && pops > 0) exp_urun = 1;
      if (!reset_n) begin
        exp_q.delete();
        active   = 0;
        exp_urun = 0;
        pops     = 0;
      end else if (start_l) begin
        exp_q.delete();
        for (int i = 0; i < LONG_WORDS; i++) exp_q.push_back(word_of(addr_at(base_l, i)));
        active   = 1;
        exp_urun = 0;
        pops     = 0;
      end
    end
  end

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done_l && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, done_l, 1);
    cyc();
  endtask

  task automatic first_word(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!(bus_l.px_valid && bus_l.px_ready) && n < 20) begin
      cyc();
      n++;
    end
    chk(tag, bus_l.px_data, exp);
  endtask

  task automatic pulse_start_l(input logic [15:0] base);
    base_l  = base;
    start_l = 1'b1;
    cyc();
    start_l = 1'b0;
  endtask

  initial begin
    int n;
    int dones_before;
    bit fin;
    int abort_at;

    bus_s.px_ready = 1'b0;
    bus_l.px_ready = 1'b0;
    cyc();
    cyc();

    chk("rst_addr_s", bus_s.vram_addr, 0);
    chk("rst_data_s", bus_s.px_data, 0);
    chk("rst_valid_s", bus_s.px_valid, 0);
    chk("rst_busy_s", busy_s, 0);
    chk("rst_done_s", done_s, 0);
    chk("rst_urun_s", underrun_s, 0);
    chk("rst_addr_l", bus_l.vram_addr, 0);
    chk("rst_data_l", bus_l.px_data, 0);
    chk("rst_valid_l", bus_l.px_valid, 0);
    chk("rst_busy_l", busy_l, 0);
    chk("we_tied", {bus_s.vram_we, bus_l.vram_we}, 0);
    chk("wdata_tied", {bus_s.vram_wdata, bus_l.vram_wdata}, 0);
    mon_en  = 1;
    reset_n = 1'b1;
    cyc();

    // Basic 4-word line, consumer always ready.
    bus_s.px_ready = 1'b1;
    base_s  = 16'h0100;
    start_s = 1'b1;
    cyc();
    start_s = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k <= 4) chk("t1_addr", bus_s.vram_addr, 16'h0100 + k - 1);
      chk("t1_valid", bus_s.px_valid, (k >= 3) && (k <= 6));
      if (k >= 3 && k <= 6) chk("t1_data", bus_s.px_data, word_of(16'(16'h0100 + k - 3)));
      chk("t1_done", done_s, k == 6);
      chk("t1_busy", busy_s, k <= 5);
      cyc();
    end

    // Backpressure: only FIFO_DEPTH reads may be outstanding.
    bus_l.px_ready = 1'b0;
    pulse_start_l(16'h0400);
    for (int k = 1; k <= 20; k++) begin
      chk("bp_addr", bus_l.vram_addr, (k <= 8) ? (16'h0400 + k - 1) : 16'h0408);
      cyc();
    end
    bus_l.px_ready = 1'b1;
    wait_done(60, "bp_done");
    chk("bp_pops", pops, LONG_WORDS);

    // Abort after three words.
    pulse_start_l(16'h0200);
    n = 0;
    while (pops < 3 && n < 30) begin
      cyc();
      n++;
    end
    chk("abort_reach3", pops >= 3, 1);
    pulse_start_l(16'h0300);
    dones_before = dones;
    first_word("abort_first", word_of(16'h0300));
    wait_done(60, "abort_done");
    chk("abort_dones", dones - dones_before, 1);
    chk("abort_pops", pops, LONG_WORDS);

    // Underrun: stream stalls on the producer side after two pops.
    pulse_start_l(16'h0500);
    n = 0;
    while (pops < 2 && n < 20) begin
      cyc();
      n++;
    end
    force bus_l.px_valid = 1'b0;
    repeat (3) cyc();
    release bus_l.px_valid;
    #1;
    chk("urun_set", underrun_l, 1);
    wait_done(60, "urun_done");
    chk("urun_sticky", underrun_l, 1);
    pulse_start_l(16'h0600);
    chk("urun_cleared", underrun_l, 0);
    wait_done(60, "urun_done2");

    // Address walk across 0x7FFF.
    pulse_start_l(16'h7FFE);
    for (int k = 0; k < 4; k++) begin
      chk("wrap_addr", bus_l.vram_addr, addr_at(16'h7FFE, k));
      cyc();
    end
    wait_done(60, "wrap_done");

    // Reset mid-line, with a start that must be ignored during reset.
    bus_l.px_ready = 1'b0;
    pulse_start_l(16'h0700);
    repeat (4) cyc();
    reset_n = 1'b0;
    base_l  = 16'h0900;
    start_l = 1'b1;
    cyc();
    reset_n = 1'b1;
    start_l = 1'b0;
    chk("mrst_addr", bus_l.vram_addr, 0);
    chk("mrst_data", bus_l.px_data, 0);
    chk("mrst_valid", bus_l.px_valid, 0);
    chk("mrst_busy", busy_l, 0);
    chk("mrst_done", done_l, 0);
    chk("mrst_urun", underrun_l, 0);
    cyc();
    chk("mrst_start_ignored", busy_l, 0);
    bus_l.px_ready = 1'b1;
    pulse_start_l(16'h0800);
    first_word("mrst_first", word_of(16'h0800));
    wait_done(60, "mrst_done_pulse");

    // Random lines with random consumer stalls and occasional aborts.
    for (int line = 0; line < 24; line++) begin
      pulse_start_l(16'($urandom));
      abort_at = (line % 4 == 3) ? int'($urandom_range(2, 15)) : -1;
      n   = 0;
      fin = 0;
      while (!fin && n < 400) begin
        bus_l.px_ready = ($urandom_range(0, 3) != 0);
        if (n == abort_at) begin
          base_l  = 16'($urandom);
          start_l = 1'b1;
        end else begin
          start_l = 1'b0;
        end
        #1;
        fin = done_l && !start_l;
        cyc();
        n++;
      end
      start_l = 1'b0;
      chk("rand_line_done", fin, 1);
    end
    cyc();
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog time=%0t limit=500000", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
